sensor_poll_scheduler: RTL

SENSOR_POLL_SCHEDULER -- requirements
Module: sensor_poll_scheduler

---
 rtl/sensor_poll_scheduler.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/sensor_poll_scheduler.sv
// Sensor poll scheduler: a prescaled base tick drives four per-channel poll timers,
// and pending requests are served one at a time on a shared converter in round-robin order.
module sensor_poll_scheduler #(
    parameter int unsigned PRESCALE = 100000,
    parameter int unsigned TIMEOUT  = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] period,
    input  logic        done,
    output logic        start,
    output logic [1:0]  ch,
    output logic        busy,
    output logic        tick,
    output logic [3:0]  pending,
    output logic [3:0]  overrun,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    localparam logic [31:0] PRE_LAST  = 32'(PRESCALE - 1);
    localparam logic [31:0] WAIT_LAST = 32'(TIMEOUT - 1);

    state_t      state;
    state_t      state_next;
    logic [31:0] pre_cnt;
    logic [7:0]  chan_cnt [4];
    logic [31:0] wait_cnt;
    logic [1:0]  last_served;
    logic [3:0]  due;
    logic [3:0]  clear;
    logic        finish;
    logic        timed_out;
    logic        pick_valid;
    logic [1:0]  pick;
    logic [1:0]  rr_idx;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            pre_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            tick    <= (pre_cnt == PRE_LAST);
            pre_cnt <= (pre_cnt == PRE_LAST) ? 32'd0 : pre_cnt + 32'd1;
        end
    end

    always_comb begin
        due = '0;
        for (int k = 0; k < 4; k++) begin
            due[k] = tick && (period[8*k +: 8] != 8'd0) && (chan_cnt[k] <= 8'd1);
        end
    end

    // A counter at 0 after reset makes the channel fire on its first tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                chan_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (period[8*k +: 8] == 8'd0) begin
                    chan_cnt[k] <= '0;
                end else if (tick) begin
                    chan_cnt[k] <= (chan_cnt[k] <= 8'd1) ? period[8*k +: 8]
                                                         : chan_cnt[k] - 8'd1;
                end
            end
        end
    end

    always_comb begin
        finish    = (state == WAIT) && (done || (wait_cnt == WAIT_LAST));
        timed_out = (state == WAIT) && !done && (wait_cnt == WAIT_LAST);
        clear     = finish ? (4'b0001 << ch) : 4'b0000;
    end

    // A new request landing on the cycle its predecessor is cleared is not an overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending     <= '0;
            overrun     <= '0;
            timeout_err <= 1'b0;
        end else begin
            pending     <= (pending & ~clear) | due;
            overrun     <= overrun | (due & pending & ~clear);
            timeout_err <= timeout_err | timed_out;
        end
    end

    always_comb begin
        pick_valid = 1'b0;
        pick       = last_served;
        rr_idx     = '0;
        for (int i = 1; i <= 4; i++) begin
            rr_idx = last_served + 2'(i);
            if (!pick_valid && pending[rr_idx]) begin
                pick_valid = 1'b1;
                pick       = rr_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (en && pick_valid) state_next = START;
            START:   state_next = WAIT;
            WAIT:    if (finish) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        start = (state == START);
        busy  = (state == START) || (state == WAIT);
    end

    // last_served starts at 3 so channel 0 wins the first arbitration.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch          <= 2'd0;
            last_served <= 2'd3;
            wait_cnt    <= '0;
        end else begin
            if (state == IDLE && en && pick_valid) begin
                ch <= pick;
            end
            if (finish) begin
                last_served <= ch;
            end
            wait_cnt <= (state == WAIT) ? wait_cnt + 32'd1 : 32'd0;
        end
    end

endmodule
